// File: rtl/q2_pkg.sv
// Shared encodings for the Q2 sequencer: 4-bit state codes and the top-level mode.
package q2_pkg;

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] LOAD     = 4'd1;
  localparam logic [3:0] DEREF    = 4'd2;
  localparam logic [3:0] EXEC     = 4'd3;
  localparam logic [3:0] ALU_BASE = 4'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DEPOSIT = 2'd2
  } mode_t;

endpackage

// File: rtl/q2_sw_sync.sv
// Two-flop synchronizer plus rising-edge detector for one front-panel switch.
module q2_sw_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  // rise is decoded purely from flops, so it is glitch-free inside the clock domain
  assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/q2_sequencer.sv
// Q2 timing/state sequencer: state bits, write strobe, run/stop/step, halt and panel deposit.
module q2_sequencer
  import q2_pkg::*;
#(
  parameter int SETTLE     = 2,
  parameter int ALU_STEPS  = 12,
  parameter int DEP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic op1,
  input  logic op2,
  input  logic op5,
  input  logic halt,
  input  logic sw_run,
  input  logic sw_stop,
  input  logic sw_step,
  input  logic sw_dep,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic ws,
  output logic dep_sw,
  output logic incp_db,
  output logic running
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int DW = $clog2(DEP_CYCLES + 1);
  localparam logic [3:0] ALU_LAST = 4'(ALU_BASE + ALU_STEPS - 1);

  logic run_rise;
  logic stop_rise;
  logic step_rise;
  logic dep_rise;

  q2_sw_sync u_sync_run  (.clk(clk), .rst_n(rst_n), .sw(sw_run),  .rise(run_rise));
  q2_sw_sync u_sync_stop (.clk(clk), .rst_n(rst_n), .sw(sw_stop), .rise(stop_rise));
  q2_sw_sync u_sync_step (.clk(clk), .rst_n(rst_n), .sw(sw_step), .rise(step_rise));
  q2_sw_sync u_sync_dep  (.clk(clk), .rst_n(rst_n), .sw(sw_dep),  .rise(dep_rise));

  function automatic logic [3:0] next_state(input logic [3:0] st, input logic o1,
                                            input logic o2, input logic o5);
    logic [3:0] nx;
    nx = FETCH;
    case (st)
      FETCH:   nx = o2 ? LOAD : (o1 ? DEREF : EXEC);
      LOAD:    nx = o1 ? DEREF : EXEC;
      DEREF:   nx = EXEC;
      EXEC:    nx = o5 ? FETCH : ALU_BASE;
      default: nx = (st == ALU_LAST) ? FETCH : st + 4'd1;
    endcase
    return nx;
  endfunction

  mode_t          mode;
  logic [3:0]     state;
  logic [CW-1:0]  cnt;
  logic [DW-1:0]  dcnt;
  logic           stop_pending;
  logic           step_pending;
  logic [3:0]     nxt_state;
  logic           end_instr;

  assign nxt_state = next_state(state, op1, op2, op5);
  assign end_instr = (nxt_state == FETCH) && (stop_pending || stop_rise || step_pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode         <= IDLE;
      state        <= FETCH;
      cnt          <= '0;
      dcnt         <= '0;
      ws           <= 1'b0;
      dep_sw       <= 1'b0;
      incp_db      <= 1'b0;
      running      <= 1'b0;
      stop_pending <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      case (mode)
        IDLE: begin
          state <= FETCH;
          cnt   <= '0;
          ws    <= 1'b0;
          // a stop edge coinciding with a run edge keeps the machine idle
          if (run_rise && !stop_rise) begin
            mode    <= ACTIVE;
            running <= 1'b1;
          end else if (step_rise) begin
            mode         <= ACTIVE;
            step_pending <= 1'b1;
          end else if (dep_rise) begin
            mode   <= DEPOSIT;
            dep_sw <= 1'b1;
            dcnt   <= '0;
          end
        end
        ACTIVE: begin
          if (stop_rise) stop_pending <= 1'b1;
          // ws is registered to mirror cnt==SETTLE, so it marks the strobe cycle
          if (ws) begin
            cnt <= '0;
            ws  <= 1'b0;
            if (halt || end_instr) begin
              mode         <= IDLE;
              state        <= FETCH;
              running      <= 1'b0;
              stop_pending <= 1'b0;
              step_pending <= 1'b0;
            end else begin
              state <= nxt_state;
            end
          end else begin
            cnt <= cnt + 1'b1;
            ws  <= (cnt == CW'(SETTLE - 1));
          end
        end
        DEPOSIT: begin
          if (dep_sw) begin
            if (dcnt == DW'(DEP_CYCLES - 1)) begin
              dep_sw  <= 1'b0;
              incp_db <= 1'b1;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end else begin
            incp_db <= 1'b0;
            mode    <= IDLE;
          end
        end
        default: mode <= IDLE;
      endcase
    end
  end

  assign {s3, s2, s1, s0} = state;

endmodule

// File: tb/tb_q2_sequencer.sv
// Directed bench for q2_sequencer: cycle table for a LOAD instruction plus multi-cycle corner sequences.
module tb_q2_sequencer;

  logic clk;
  logic rst_n;
  logic op1, op2, op5, halt;
  logic sw_run, sw_stop, sw_step, sw_dep;
  logic s0, s1, s2, s3, ws, dep_sw, incp_db, running;

  int checks   = 0;
  int failures = 0;

  q2_sequencer #(.SETTLE(2), .ALU_STEPS(12), .DEP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .op1(op1), .op2(op2), .op5(op5), .halt(halt),
    .sw_run(sw_run), .sw_stop(sw_stop), .sw_step(sw_step), .sw_dep(sw_dep),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .ws(ws), .dep_sw(dep_sw),
    .incp_db(incp_db), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic       o1;
    logic       o2;
    logic       o5;
    logic [7:0] exp;   // {state[3:0], ws, running, dep_sw, incp_db}
  } vec_t;

  vec_t       vec [12];
  logic [1:0] dep_exp [8];
  logic [3:0] alu_seq [15];

  function automatic logic [3:0] st();
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [7:0] outs();
    return {s3, s2, s1, s0, ws, running, dep_sw, incp_db};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  initial begin
    int pulses;
    int bad;
    logic [3:0] last_ws_st;

    vec[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
    vec[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
    vec[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h04};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h04};
    vec[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h0C};
    vec[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h14};
    vec[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h14};
    vec[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h1C};
    vec[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h34};
    vec[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h34};
    vec[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h3C};
    vec[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h04};
    dep_exp[0] = 2'b00; dep_exp[1] = 2'b00; dep_exp[2] = 2'b10; dep_exp[3] = 2'b10;
    dep_exp[4] = 2'b01; dep_exp[5] = 2'b00; dep_exp[6] = 2'b00; dep_exp[7] = 2'b00;
    alu_seq[0] = 4'd0; alu_seq[1] = 4'd2; alu_seq[2] = 4'd3;
    for (int k = 3; k < 15; k++) alu_seq[k] = 4'(k + 1);

    rst_n = 1'b0; op1 = 0; op2 = 0; op5 = 1; halt = 0;
    sw_run = 0; sw_stop = 0; sw_step = 0; sw_dep = 0;
    #23;
    check("reset_outputs", 32'(outs()), 32'h00);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("idle_after_reset", 32'(outs()), 32'h00);

    // run, LOAD instruction cycle by cycle
    for (int i = 0; i < 12; i++) begin
      sw_run = vec[i].run; op1 = vec[i].o1; op2 = vec[i].o2; op5 = vec[i].o5;
      tick();
      check($sformatf("load_vec%0d", i), 32'(outs()), 32'(vec[i].exp));
    end

    // ALU instruction, with a deposit edge that must be ignored while running
    op5 = 0; op1 = 1; op2 = 0; sw_dep = 1;
    pulses = 0; bad = 0;
    for (int i = 0; i < 44; i++) begin
      tick();
      if (dep_sw) bad++;
      if (ws) begin
        if (pulses < 15) check($sformatf("alu_ws_state%0d", pulses), 32'(st()), 32'(alu_seq[pulses]));
        pulses++;
      end
    end
    check("alu_ws_pulses", 32'(pulses), 32'd15);
    check("dep_ignored_running", 32'(bad), 32'd0);
    tick();
    check("alu_back_fetch", 32'({st(), ws, running}), 32'h01);
    sw_dep = 0;

    // stop mid-ALU: instruction completes, then idle
    for (int i = 0; i < 100 && st() != 4'd7; i++) tick();
    check("reach_alu7", 32'(st()), 32'd7);
    sw_stop = 1;
    last_ws_st = 4'hx;
    for (int i = 0; i < 200 && running; i++) begin
      tick();
      if (ws) last_ws_st = st();
    end
    check("stop_running_low", 32'(running), 32'd0);
    check("stop_last_state", 32'(last_ws_st), 32'd15);
    check("stop_idle_outputs", 32'(outs()), 32'h00);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (outs() != 8'h00) bad++;
    end
    check("stop_stays_idle", 32'(bad), 32'd0);
    sw_stop = 0;

    // halt ignored off-strobe, honoured on EXEC strobe
    sw_run = 0; op2 = 0; op1 = 0; op5 = 0;
    repeat (3) tick();
    sw_run = 1;
    for (int i = 0; i < 10 && !running; i++) tick();
    check("run_restart", 32'(running), 32'd1);
    halt = 1;
    tick();
    halt = 0;
    check("halt_no_ws_ignored", 32'(running), 32'd1);
    for (int i = 0; i < 50 && !(st() == 4'd3 && ws); i++) tick();
    check("reach_exec_ws", 32'({st(), ws}), 32'h07);
    halt = 1;
    tick();
    halt = 0;
    check("halt_to_idle", 32'({st(), ws, running}), 32'h00);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (outs() != 8'h00) bad++;
    end
    check("halt_stays_idle", 32'(bad), 32'd0);

    // single step: one FETCH/LOAD/DEREF/EXEC instruction, running stays 0
    op2 = 1; op1 = 1; op5 = 1; sw_step = 1;
    pulses = 0; bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ws) pulses++;
      if (running) bad++;
    end
    check("step_ws_pulses", 32'(pulses), 32'd4);
    check("step_running_low", 32'(bad), 32'd0);
    check("step_idle_end", 32'(outs()), 32'h00);
    sw_step = 0;

    // deposit from idle
    sw_dep = 1;
    for (int t = 0; t < 8; t++) begin
      tick();
      check($sformatf("dep_t%0d", t), 32'({dep_sw, incp_db}), 32'(dep_exp[t]));
    end
    sw_dep = 0;

    // simultaneous run and stop edges while idle
    sw_run = 0; sw_stop = 0;
    repeat (3) tick();
    sw_run = 1; sw_stop = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (running || ws) bad++;
    end
    check("run_stop_same_idle", 32'(bad), 32'd0);
    sw_run = 0; sw_stop = 0;
    repeat (3) tick();

    // asynchronous reset in DEREF
    op2 = 0; op1 = 1; op5 = 1; sw_run = 1;
    for (int i = 0; i < 30 && st() != 4'd2; i++) tick();
    check("reach_deref", 32'(st()), 32'd2);
    #3;
    rst_n = 1'b0;
    sw_run = 0;
    #1;
    check("async_reset_outputs", 32'(outs()), 32'h00);
    #2;
    check("reset_no_ws", 32'(ws), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (outs() != 8'h00) bad++;
    end
    check("post_reset_idle", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
